// File: rtl/time_pkg.sv
// Shared definitions for the wall-clock time scheduler.
// Contents: BCD limit constants, the service-select enum, the packed time
// record and the BCD increment helpers used by time_update_sched.
package time_pkg;

  localparam logic [3:0] MIN_TENS_MAX       = 4'd5;
  localparam logic [3:0] UNITS_MAX          = 4'd9;
  localparam logic [3:0] HRS_TENS_MAX       = 4'd2;
  localparam logic [3:0] HRS_UNITS_MAX_AT_2 = 4'd3;
  localparam logic [5:0] SEC_MAX            = 6'd59;

  typedef enum logic [1:0] {
    SVC_NONE,
    SVC_HRS,
    SVC_MIN,
    SVC_TICK
  } svc_e;

  typedef struct packed {
    logic [3:0] hours2;
    logic [3:0] hours1;
    logic [3:0] mins2;
    logic [3:0] mins1;
    logic [5:0] seconds;
  } clock_time_t;

  // Hours +1, 23 wraps to 00; minutes and seconds untouched.
  function automatic clock_time_t hrs_inc(input clock_time_t t);
    clock_time_t r;
    r = t;
    if (t.hours2 == HRS_TENS_MAX && t.hours1 == HRS_UNITS_MAX_AT_2) begin
      r.hours2 = '0;
      r.hours1 = '0;
    end else if (t.hours1 == UNITS_MAX) begin
      r.hours2 = t.hours2 + 4'd1;
      r.hours1 = '0;
    end else begin
      r.hours1 = t.hours1 + 4'd1;
    end
    return r;
  endfunction

  // Minutes +1, 59 wraps to 00 without touching hours.
  function automatic clock_time_t min_inc(input clock_time_t t);
    clock_time_t r;
    r = t;
    if (t.mins1 == UNITS_MAX) begin
      r.mins1 = '0;
      r.mins2 = (t.mins2 == MIN_TENS_MAX) ? 4'd0 : t.mins2 + 4'd1;
    end else begin
      r.mins1 = t.mins1 + 4'd1;
    end
    return r;
  endfunction

  // True when a minute increment rolls 59 over to 00.
  function automatic logic min_wrap(input clock_time_t t);
    return (t.mins2 == MIN_TENS_MAX) && (t.mins1 == UNITS_MAX);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// 1 s tick prescaler.
// Ports:
//   CLK100MHZ - system clock
//   Reset     - synchronous active-high reset
//   clr       - synchronous clear of the count (time cleared)
//   en        - 1 = count, 0 = hold
//   tick      - one-cycle strobe while the count sits at TICK_DIV-1 and
//               is enabled; the count wraps to 0 on that same edge
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned PRESC_W  = 27
) (
  input  logic CLK100MHZ,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] count;

  assign tick = en && !clr && (count == LAST);

  always_ff @(posedge CLK100MHZ) begin
    if (Reset || clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/time_update_sched.sv
// Scheduler/arbiter for the wall-clock time registers.
// Queues the 1 s tick and the minute/hour request pulses as pending flags
// and applies at most one update per edge (hours > minutes > tick).
// Ports:
//   CLK100MHZ, Reset            - clock, synchronous active-high reset
//   tick_en                     - prescaler run/hold
//   min_req, hrs_req, clr_req   - one-cycle request pulses
//   hours2, hours1, mins2, mins1 - BCD digits to SS_Driver
//   seconds                     - binary seconds 0..59
//   sec_pulse, ack_min, ack_hrs - one-cycle strobes aligned with the update
//   overrun                     - sticky duplicate-request flag
module time_update_sched
  import time_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned PRESC_W  = 27
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic       tick_en,
  input  logic       min_req,
  input  logic       hrs_req,
  input  logic       clr_req,
  output logic [3:0] hours2,
  output logic [3:0] hours1,
  output logic [3:0] mins2,
  output logic [3:0] mins1,
  output logic [5:0] seconds,
  output logic       sec_pulse,
  output logic       ack_min,
  output logic       ack_hrs,
  output logic       overrun
);

  clock_time_t cur;
  clock_time_t nxt;
  svc_e        svc;
  logic        tick;
  logic        pend_tick;
  logic        pend_min;
  logic        pend_hrs;
  logic        dup_hrs;
  logic        dup_min;
  logic        dup_tick;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV),
    .PRESC_W (PRESC_W)
  ) u_presc (
    .CLK100MHZ(CLK100MHZ),
    .Reset    (Reset),
    .clr      (clr_req),
    .en       (tick_en),
    .tick     (tick)
  );

  always_comb begin
    svc = SVC_NONE;
    if (pend_hrs)       svc = SVC_HRS;
    else if (pend_min)  svc = SVC_MIN;
    else if (pend_tick) svc = SVC_TICK;
  end

  always_comb begin
    nxt = cur;
    case (svc)
      SVC_HRS: nxt = hrs_inc(cur);
      SVC_MIN: begin
        nxt         = min_inc(cur);
        nxt.seconds = '0;
      end
      SVC_TICK: begin
        if (cur.seconds == SEC_MAX) begin
          nxt         = min_inc(cur);
          nxt.seconds = '0;
          if (min_wrap(cur)) nxt = hrs_inc(nxt);
        end else begin
          nxt.seconds = cur.seconds + 6'd1;
        end
      end
      default: nxt = cur;
    endcase
  end

  // A request that lands on the edge its own flag is being serviced simply
  // re-arms the flag; only a still-waiting flag counts as a duplicate.
  assign dup_hrs  = hrs_req && pend_hrs  && (svc != SVC_HRS);
  assign dup_min  = min_req && pend_min  && (svc != SVC_MIN);
  assign dup_tick = tick    && pend_tick && (svc != SVC_TICK);

  always_ff @(posedge CLK100MHZ) begin
    if (Reset) begin
      cur       <= '0;
      pend_tick <= 1'b0;
      pend_min  <= 1'b0;
      pend_hrs  <= 1'b0;
      sec_pulse <= 1'b0;
      ack_min   <= 1'b0;
      ack_hrs   <= 1'b0;
      overrun   <= 1'b0;
    end else if (clr_req) begin
      // Clear beats any service due this edge and drops same-cycle requests.
      cur       <= '0;
      pend_tick <= 1'b0;
      pend_min  <= 1'b0;
      pend_hrs  <= 1'b0;
      sec_pulse <= 1'b0;
      ack_min   <= 1'b0;
      ack_hrs   <= 1'b0;
    end else begin
      cur       <= nxt;
      pend_hrs  <= (pend_hrs  && (svc != SVC_HRS))  || hrs_req;
      pend_min  <= (pend_min  && (svc != SVC_MIN))  || min_req;
      pend_tick <= (pend_tick && (svc != SVC_TICK)) || tick;
      ack_hrs   <= (svc == SVC_HRS);
      ack_min   <= (svc == SVC_MIN);
      sec_pulse <= (svc == SVC_TICK);
      if (dup_hrs || dup_min || dup_tick) overrun <= 1'b1;
    end
  end

  assign hours2  = cur.hours2;
  assign hours1  = cur.hours1;
  assign mins2   = cur.mins2;
  assign mins1   = cur.mins1;
  assign seconds = cur.seconds;

endmodule

// File: tb/tb_time_update_sched.sv
// Scoreboard bench for time_update_sched (TICK_DIV=4).
// Stimulus pushes {kind, resulting time, cycle} entries; the monitor pops one
// whenever a strobe appears. The reference time is kept as seconds-of-day.
module tb_time_update_sched;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       tick_en = 1'b0;
  logic       min_req = 1'b0;
  logic       hrs_req = 1'b0;
  logic       clr_req = 1'b0;
  logic [3:0] hours2, hours1, mins2, mins1;
  logic [5:0] seconds;
  logic       sec_pulse, ack_min, ack_hrs, overrun;

  time_update_sched #(.TICK_DIV(4), .PRESC_W(3)) dut (
    .CLK100MHZ(clk),
    .Reset    (Reset),
    .tick_en  (tick_en),
    .min_req  (min_req),
    .hrs_req  (hrs_req),
    .clr_req  (clr_req),
    .hours2   (hours2),
    .hours1   (hours1),
    .mins2    (mins2),
    .mins1    (mins1),
    .seconds  (seconds),
    .sec_pulse(sec_pulse),
    .ack_min  (ack_min),
    .ack_hrs  (ack_hrs),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 1 = hour, 2 = minute, 3 = tick
    int t;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   mt = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [21:0] digits(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 6'(s)};
  endfunction

  function automatic logic [21:0] dut_time();
    return {hours2, hours1, mins2, mins1, seconds};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_time(input string name);
    chk(name, {10'd0, dut_time()}, {10'd0, digits(mt)});
  endtask

  task automatic push(input int kind, input int when);
    exp_t e;
    e.kind = kind;
    e.t    = mt;
    e.cyc  = when;
    q.push_back(e);
  endtask

  task automatic m_hrs();
    mt = ((mt / 3600 + 1) % 24) * 3600 + (mt % 3600);
  endtask

  task automatic m_min();
    mt = (mt / 3600) * 3600 + (((mt / 60) % 60 + 1) % 60) * 60;
  endtask

  task automatic m_tick();
    mt = (mt + 1) % 86400;
  endtask

  // Back-to-back single requests; each serviced two edges after it is driven.
  task automatic hrs_n(input int n);
    for (int i = 0; i < n; i++) begin
      m_hrs();
      push(1, cyc + 2);
      hrs_req = 1'b1;
      step();
      hrs_req = 1'b0;
    end
    step();
    step();
  endtask

  task automatic min_n(input int n);
    for (int i = 0; i < n; i++) begin
      m_min();
      push(2, cyc + 2);
      min_req = 1'b1;
      step();
      min_req = 1'b0;
    end
    step();
    step();
  endtask

  // Prescaler must be at 0 and held; the n-th tick is applied at k+1+4n.
  task automatic run_ticks(input int n);
    int k;
    k = cyc;
    for (int i = 1; i <= n; i++) begin
      m_tick();
      push(3, k + 1 + 4 * i);
    end
    tick_en = 1'b1;
    repeat (4 * n) step();
    tick_en = 1'b0;
  endtask

  task automatic clear();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    mt = 0;
  endtask

  always @(negedge clk) begin
    int   nstb, akind;
    exp_t e;
    nstb = int'(sec_pulse) + int'(ack_min) + int'(ack_hrs);
    if (nstb > 0) begin
      checks++;
      akind = ack_hrs ? 1 : (ack_min ? 2 : 3);
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected strobe kind=%0d time=%0h at cycle %0d, expected none",
                 akind, dut_time(), cyc);
      end else begin
        e = q.pop_front();
        if (nstb != 1 || akind != e.kind || dut_time() != digits(e.t) ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL scoreboard: got kind=%0d(n=%0d) time=%0h cycle=%0d, expected kind=%0d time=%0h cycle=%0d",
                   akind, nstb, dut_time(), cyc, e.kind, digits(e.t), e.cyc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state
    repeat (3) step();
    Reset = 1'b0;
    chk("reset_state", {6'd0, dut_time(), sec_pulse, ack_min, ack_hrs, overrun}, 32'd0);

    // 1: 60 ticks from reset -> 00:01:00
    run_ticks(60);
    step();
    step();
    chk_time("ticks60_time");
    chk("ticks60_overrun", {31'd0, overrun}, 32'd0);

    // 2: preload 23:59:59, then wrap to 00:00:00
    clear();
    hrs_n(23);
    min_n(59);
    run_ticks(59);
    step();
    chk_time("preload_235959");
    run_ticks(1);
    step();
    chk("wrap_pulse_hi", {31'd0, sec_pulse}, 32'd1);
    chk_time("wrap_000000");
    step();
    chk("wrap_pulse_lo", {31'd0, sec_pulse}, 32'd0);

    // 3: hour, minute and tick pending together
    k = cyc;
    tick_en = 1'b1;
    repeat (3) step();
    m_hrs();  push(1, k + 5);
    m_min();  push(2, k + 6);
    m_tick(); push(3, k + 7);
    hrs_req = 1'b1;
    min_req = 1'b1;
    step();
    hrs_req = 1'b0;
    min_req = 1'b0;
    tick_en = 1'b0;
    repeat (4) step();
    chk_time("contend_time");
    chk("contend_overrun", {31'd0, overrun}, 32'd0);

    // 4: minute wrap without hour carry, hour wrap 23 -> 00
    clear();
    hrs_n(5);
    min_n(59);
    chk_time("at_0559");
    min_n(1);
    chk_time("min_wrap_0500");
    hrs_n(18);
    min_n(7);
    hrs_n(1);
    chk_time("hrs_wrap_0007");

    // 5a: hour re-requested on its service edge -> no overrun
    k = cyc;
    m_min(); push(2, k + 2);
    m_hrs(); push(1, k + 3);
    m_hrs(); push(1, k + 4);
    min_req = 1'b1;
    step();
    min_req = 1'b0;
    hrs_req = 1'b1;
    step();
    step();
    hrs_req = 1'b0;
    repeat (3) step();
    chk("resvc_overrun", {31'd0, overrun}, 32'd0);
    chk_time("resvc_time");

    // 5b: minute duplicated while held off by hours -> overrun, one min applied
    k = cyc;
    m_hrs(); push(1, k + 2);
    m_hrs(); push(1, k + 3);
    m_hrs(); push(1, k + 4);
    m_min(); push(2, k + 5);
    hrs_req = 1'b1;
    min_req = 1'b1;
    step();
    step();
    min_req = 1'b0;
    step();
    hrs_req = 1'b0;
    repeat (4) step();
    chk("dup_overrun", {31'd0, overrun}, 32'd1);
    chk_time("dup_time");

    // 6: clear at 12:34:56 with a pending minute and prescaler mid-count
    clear();
    hrs_n(12);
    min_n(34);
    run_ticks(56);
    step();
    chk_time("at_123456");
    k = cyc;
    tick_en = 1'b1;
    step();
    min_req = 1'b1;
    step();
    min_req = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    mt = 0;
    chk_time("clr_time");
    chk("clr_no_ack", {31'd0, ack_min}, 32'd0);
    chk("clr_overrun_sticky", {31'd0, overrun}, 32'd1);
    m_tick();
    push(3, k + 8);
    repeat (7) step();
    chk("pre_reset_overrun", {31'd0, overrun}, 32'd1);

    // Reset mid-run, just before the next tick would be raised
    Reset   = 1'b1;
    tick_en = 1'b0;
    step();
    chk("midrun_reset", {6'd0, dut_time(), sec_pulse, ack_min, ack_hrs, overrun}, 32'd0);
    Reset = 1'b0;
    repeat (6) step();
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
